// File: rtl/minmax_pkg.sv
// Shared constants for the N-channel min/max acquisition unit:
// controller state encoding and selection-mode values.
package minmax_pkg;

  localparam logic [2:0] S_SOC  = 3'd0;
  localparam logic [2:0] S_EOC  = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_DAV  = 3'd3;
  localparam logic [2:0] S_ACK  = 3'd4;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/minmax_cmp.sv
// Unsigned "b strictly better than a" comparator. Min mode asks b < a,
// max mode asks a < b; both reduce to the borrow out of one W-bit
// subtraction with the operands swapped by mode.
module minmax_cmp
  import minmax_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         mode_i,
  output logic         better_o
);

  logic [W-1:0] lhs;
  logic [W-1:0] rhs;
  logic [W-1:0] diff_unused;
  logic         borrow;

  // Pick subtraction operand order so that a borrow means "b wins".
  always_comb begin
    if (mode_i == MODE_MAX) begin
      lhs = a_i;
      rhs = b_i;
    end else begin
      lhs = b_i;
      rhs = a_i;
    end
  end

  assign {borrow, diff_unused} = {1'b0, lhs} - {1'b0, rhs};
  assign better_o = borrow;

endmodule

// File: rtl/minmax_nch_acq.sv
// N-channel acquisition and min/max selection. Starts all converters with
// one shared soc, waits for every eoc, captures the samples, then walks
// them one channel per clock and presents the winner on a dav_/rfd
// handshake. Define MINMAX_IDX_EN to add the winning-channel index port.
//
// state  | meaning
// S_SOC  | soc high, waiting for all eoc low
// S_EOC  | soc low, waiting for all eoc high (capture edge)
// S_SCAN | one comparison per clock until every channel is seen
// S_DAV  | result valid (dav_ low) until the consumer drops rfd
// S_ACK  | waiting for rfd to return high before the next conversion
module minmax_nch_acq
  import minmax_pkg::*;
#(
  parameter  int N  = 3,
  parameter  int W  = 8,
  localparam int IW = $clog2((N > 1) ? N : 2)
) (
  input  logic [0:0]     clock,
  input  logic           reset_,
  input  logic [N*W-1:0] x,
  input  logic [N-1:0]   eoc,
  input  logic           mode,
  input  logic           rfd,
  output logic           soc,
  output logic           dav_,
  output logic [W-1:0]   out
`ifdef MINMAX_IDX_EN
  ,
  output logic [IW-1:0]  idx
`endif
);

  localparam int            CW  = $clog2(N + 1);
  localparam logic [CW-1:0] N_C = CW'(N);

  logic [2:0]    state_q, state_d;
  logic          soc_q, soc_d;
  logic          dav_q, dav_d;
  logic          ld_cap, ld_step, ld_out;
  logic          all_lo, all_hi, scan_done, better;
  logic [W-1:0]  buf_q [N];
  logic [W-1:0]  acc_q, out_q, cand;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] cnt_ix;
  logic          m_q;
`ifdef MINMAX_IDX_EN
  logic [IW-1:0] accidx_q, idx_q;
`endif

  // Datapath status returned to the controller.
  assign all_lo    = (eoc == '0);
  assign all_hi    = (eoc == '1);
  assign scan_done = (cnt_q == N_C);
  assign cnt_ix    = cnt_q[IW-1:0];
  assign cand      = buf_q[cnt_ix];

  minmax_cmp #(.W(W)) u_cmp (
    .a_i     (acc_q),
    .b_i     (cand),
    .mode_i  (m_q),
    .better_o(better)
  );

  // Controller: next state and datapath load strobes.
  always_comb begin
    state_d = state_q;
    ld_cap  = 1'b0;
    ld_step = 1'b0;
    ld_out  = 1'b0;
    case (state_q)
      S_SOC:  if (all_lo) state_d = S_EOC;
      S_EOC:  if (all_hi) begin
                ld_cap  = 1'b1;
                state_d = S_SCAN;
              end
      S_SCAN: if (scan_done) begin
                ld_out  = 1'b1;
                state_d = S_DAV;
              end else begin
                ld_step = 1'b1;
              end
      S_DAV:  if (!rfd) state_d = S_ACK;
      S_ACK:  if (rfd) state_d = S_SOC;
      default: state_d = S_SOC;
    endcase
  end

  // Registered handshake outputs derived from the current state.
  always_comb begin
    soc_d = (state_q == S_SOC);
    dav_d = dav_q;
    if (ld_out) dav_d = 1'b0;
    if ((state_q == S_DAV) && !rfd) dav_d = 1'b1;
  end

  // Controller registers.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_SOC;
      soc_q   <= 1'b0;
      dav_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      soc_q   <= soc_d;
      dav_q   <= dav_d;
    end
  end

  // Datapath: capture, sequential scan and result registers.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      for (int k = 0; k < N; k++) buf_q[k] <= '0;
      acc_q <= '0;
      out_q <= '0;
      cnt_q <= '0;
      m_q   <= MODE_MIN;
`ifdef MINMAX_IDX_EN
      accidx_q <= '0;
      idx_q    <= '0;
`endif
    end else begin
      if (ld_cap) begin
        for (int k = 0; k < N; k++) buf_q[k] <= x[k*W +: W];
        acc_q <= x[W-1:0];
        m_q   <= mode;
        cnt_q <= CW'(1);
`ifdef MINMAX_IDX_EN
        accidx_q <= '0;
`endif
      end
      if (ld_step) begin
        // Strict compare keeps the earlier channel on ties.
        if (better) begin
          acc_q <= cand;
`ifdef MINMAX_IDX_EN
          accidx_q <= cnt_ix;
`endif
        end
        cnt_q <= cnt_q + CW'(1);
      end
      if (ld_out) begin
        out_q <= acc_q;
`ifdef MINMAX_IDX_EN
        idx_q <= accidx_q;
`endif
      end
    end
  end

  assign soc  = soc_q;
  assign dav_ = dav_q;
  assign out  = out_q;
`ifdef MINMAX_IDX_EN
  assign idx  = idx_q;
`endif

endmodule

// File: tb/tb_minmax_nch_acq.sv
// Bench for minmax_nch_acq: directed runs on N=3/W=8, a single-channel
// N=1/W=12 instance and randomized N=8 runs against a reference model.
module tb_minmax_nch_acq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_;

  logic [23:0] x3;  logic [2:0] eoc3; logic mode3, rfd3, soc3, dav3; logic [7:0]  out3;
  logic [11:0] x1;  logic [0:0] eoc1; logic mode1, rfd1, soc1, dav1; logic [11:0] out1;
  logic [63:0] x8;  logic [7:0] eoc8; logic mode8, rfd8, soc8, dav8; logic [7:0]  out8;
`ifdef MINMAX_IDX_EN
  logic [1:0] idx3; logic [0:0] idx1; logic [2:0] idx8;
`endif

  minmax_nch_acq #(.N(3), .W(8)) u3 (
    .clock(clock), .reset_(reset_), .x(x3), .eoc(eoc3), .mode(mode3), .rfd(rfd3),
    .soc(soc3), .dav_(dav3), .out(out3)
`ifdef MINMAX_IDX_EN
    , .idx(idx3)
`endif
  );

  minmax_nch_acq #(.N(1), .W(12)) u1 (
    .clock(clock), .reset_(reset_), .x(x1), .eoc(eoc1), .mode(mode1), .rfd(rfd1),
    .soc(soc1), .dav_(dav1), .out(out1)
`ifdef MINMAX_IDX_EN
    , .idx(idx1)
`endif
  );

  minmax_nch_acq #(.N(8), .W(8)) u8 (
    .clock(clock), .reset_(reset_), .x(x8), .eoc(eoc8), .mode(mode8), .rfd(rfd8),
    .soc(soc8), .dav_(dav8), .out(out8)
`ifdef MINMAX_IDX_EN
    , .idx(idx8)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // From S_SOC/S_ACK, drop eoc and run until soc is seen high: the unit is then in S_EOC.
  task automatic sync3(input string tag);
    int n;
    eoc3 = '0;
    n = 0;
    do begin tick; n++; end while (soc3 !== 1'b1 && n < 50);
    chk(tag, soc3, 1);
  endtask

  // Present samples with all eoc high; the following edge is the capture edge E.
  task automatic start3(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                        input logic mv);
    x3 = {c2, c1, c0};
    mode3 = mv;
    eoc3 = 3'b111;
    tick;
  endtask

  // Cycles from E until dav_ is seen low.
  task automatic wait_dav3(output int lat);
    lat = 0;
    do begin tick; lat++; end while (dav3 !== 1'b0 && lat < 40);
  endtask

  task automatic end3(input string tag);
    rfd3 = 1'b0;
    tick;
    chk({tag, "_dav_rel"}, dav3, 1);
    rfd3 = 1'b1;
    sync3({tag, "_sync"});
  endtask

  // Reference: extreme value by full search, winner = first channel holding it.
  task automatic ref8(input int v[8], input logic md, output int val, output int ix);
    val = md ? 0 : 255;
    for (int k = 0; k < 8; k++) begin
      if (md && v[k] >= val) val = v[k];
      if (!md && v[k] <= val) val = v[k];
    end
    ix = -1;
    for (int k = 0; k < 8; k++) if (ix < 0 && v[k] == val) ix = k;
  endtask

  initial begin
    int lat, n, ev, eix, hold;
    int v[8];
    logic md, early;

    reset_ = 1'b0;
    x3 = '0; eoc3 = '0; mode3 = 1'b0; rfd3 = 1'b1;
    x1 = '0; eoc1 = '0; mode1 = 1'b0; rfd1 = 1'b1;
    x8 = '0; eoc8 = '0; mode8 = 1'b0; rfd8 = 1'b1;
    #12;
    chk("rst_soc", soc3, 0);
    chk("rst_dav", dav3, 1);
    chk("rst_out", out3, 0);
    chk("rst_dav8", dav8, 1);
    #10 reset_ = 1'b1;
    tick;
    chk("soc_first_edge", soc3, 1);
    tick;
    chk("soc_pulse_end", soc3, 0);

    // 1: minimum, channel 1 wins, dav_ at E+3.
    start3(8'h40, 8'h10, 8'h90, 1'b0);
    wait_dav3(lat);
    chk("t1_lat", lat, 3);
    chk("t1_out", out3, 8'h10);
`ifdef MINMAX_IDX_EN
    chk("t1_idx", idx3, 1);
`endif
    tick; tick;
    chk("t1_dav_hold", dav3, 0);
    chk("t1_out_hold", out3, 8'h10);
    end3("t1");
    chk("t1_out_after", out3, 8'h10);

    // 2: maximum with a tie; changes after E are ignored.
    start3(8'hFF, 8'h00, 8'hFF, 1'b1);
    mode3 = 1'b0;
    x3 = 24'h000000;
    wait_dav3(lat);
    chk("t2_lat", lat, 3);
    chk("t2_out", out3, 8'hFF);
`ifdef MINMAX_IDX_EN
    chk("t2_idx", idx3, 0);
`endif
    end3("t2");

    // 3: partial eoc holds off the capture.
    x3 = {8'h33, 8'h05, 8'h22};
    eoc3 = 3'b101;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("t3_soc_low", soc3, 0);
      chk("t3_no_dav", dav3, 1);
    end
    start3(8'h22, 8'h05, 8'h33, 1'b0);
    wait_dav3(lat);
    chk("t3_lat", lat, 3);
    chk("t3_out", out3, 8'h05);
`ifdef MINMAX_IDX_EN
    chk("t3_idx", idx3, 1);
`endif
    end3("t3");

    // 4: rfd already low -> one-cycle dav_, then parked in S_ACK.
    start3(8'h01, 8'h7E, 8'h7F, 1'b1);
    rfd3 = 1'b0;
    wait_dav3(lat);
    chk("t4_lat", lat, 3);
    chk("t4_out", out3, 8'h7F);
`ifdef MINMAX_IDX_EN
    chk("t4_idx", idx3, 2);
`endif
    tick;
    chk("t4_dav_one", dav3, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t4_ack_soc", soc3, 0);
    end
    rfd3 = 1'b1;
    tick;
    chk("t4_soc_ack_edge", soc3, 0);
    tick;
    chk("t4_soc_rise", soc3, 1);

    // 5: reset mid-scan aborts with no result.
    sync3("t5_sync");
    start3(8'h11, 8'h22, 8'h33, 1'b1);
    tick;
    #2 reset_ = 1'b0;
    #1;
    chk("t5_soc", soc3, 0);
    chk("t5_dav", dav3, 1);
    chk("t5_out", out3, 0);
    #2 reset_ = 1'b1;
    tick;
    chk("t5_soc_rise", soc3, 1);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t5_no_result", dav3, 1);
    end

    // 6a: single channel, result one edge after capture.
    x1 = 12'hABC;
    eoc1 = 1'b1;
    tick;
    x1 = 12'h000;
    lat = 0;
    do begin tick; lat++; end while (dav1 !== 1'b0 && lat < 40);
    chk("t6_n1_lat", lat, 1);
    chk("t6_n1_out", out1, 12'hABC);
`ifdef MINMAX_IDX_EN
    chk("t6_n1_idx", idx1, 0);
`endif
    rfd1 = 1'b0;
    tick;
    chk("t6_n1_dav_rel", dav1, 1);

    // 6b: N=8 randomized runs in both modes.
    for (int r = 0; r < 1000; r++) begin
      md = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) begin
        if (r % 7 == 3) v[k] = 8'h5A;
        else if ($urandom_range(0, 3) == 0) v[k] = int'($urandom_range(0, 3));
        else v[k] = int'($urandom_range(0, 255));
        x8[k*8 +: 8] = 8'(v[k]);
      end
      ref8(v, md, ev, eix);
      mode8 = md;
      eoc8 = 8'hFF;
      tick;
      mode8 = ~md;
      x8 = {$urandom, $urandom};
      early = ($urandom_range(0, 3) == 0);
      if (early) rfd8 = 1'b0;
      lat = 0;
      do begin tick; lat++; end while (dav8 !== 1'b0 && lat < 40);
      chk("t6_n8_lat", lat, 8);
      chk("t6_n8_out", out8, ev);
`ifdef MINMAX_IDX_EN
      chk("t6_n8_idx", idx8, eix);
`endif
      if (!early) begin
        hold = int'($urandom_range(0, 2));
        for (int h = 0; h < hold; h++) tick;
        rfd8 = 1'b0;
      end
      tick;
      chk("t6_n8_dav_rel", dav8, 1);
      rfd8 = 1'b1;
      eoc8 = '0;
      n = 0;
      do begin tick; n++; end while (soc8 !== 1'b1 && n < 50);
      chk("t6_n8_sync", soc8, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
